// File: rtl/mem_interface_if.sv
// mem_interface bus bundle: datapath-side controls plus RAM-side port.
// master = datapath/RAM environment, slave = the mem_interface block.
interface mem_interface_if;
  logic [31:0] bus_in;
  logic        mar_in;
  logic        mdr_in;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [31:0] mdr_out_data;
  logic        busy;
  logic        mem_done;
  logic [8:0]  ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;
  logic        addr_err;

  modport master (
    output bus_in, mar_in, mdr_in,
    output mem_read_req, mem_write_req,
    output ram_data_out,
    input  mdr_out_data, busy, mem_done,
    input  ram_address, ram_read, ram_write,
    input  ram_data_in, addr_err
  );

  modport slave (
    input  bus_in, mar_in, mdr_in,
    input  mem_read_req, mem_write_req,
    input  ram_data_out,
    output mdr_out_data, busy, mem_done,
    output ram_address, ram_read, ram_write,
    output ram_data_in, addr_err
  );
endinterface

// File: rtl/mem_interface.sv
// MAR/MDR memory interface with a read/write sequencer to a sync RAM.
// Optional MAR_RANGE_CHECK_EN flags MAR loads above 9 bits.
module mem_interface (
  input logic            clock,
  input logic            clear_n,
  mem_interface_if.slave mem
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAP,
    WR,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [8:0]  mar_q;
  logic [31:0] mdr_q;
  logic        err_q;
  logic        idle;
  logic        req;
  logic        load_ok;

  assign idle = (state_q == IDLE);
  assign req  = mem.mem_read_req | mem.mem_write_req;
  // An accepted request wins over a same-edge load, so the
  // access runs on the MAR/MDR values held before that edge.
  assign load_ok = idle & ~req;

  assign mem.ram_address  = mar_q;
  assign mem.ram_data_in  = mdr_q;
  assign mem.mdr_out_data = mdr_q;
  assign mem.addr_err     = err_q;

  // State register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and strobes, decoded from the registered state only.
  always_comb begin
    state_d       = state_q;
    mem.busy      = 1'b0;
    mem.ram_read  = 1'b0;
    mem.ram_write = 1'b0;
    mem.mem_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem.mem_write_req)
          state_d = err_q ? DONE : WR;
        else if (mem.mem_read_req)
          state_d = err_q ? DONE : RD_ISSUE;
      end
      RD_ISSUE: begin
        mem.busy     = 1'b1;
        mem.ram_read = 1'b1;
        state_d      = RD_CAP;
      end
      RD_CAP: begin
        mem.busy = 1'b1;
        state_d  = DONE;
      end
      WR: begin
        mem.busy      = 1'b1;
        mem.ram_write = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        mem.busy     = 1'b1;
        mem.mem_done = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // MAR: loads only while idle with no request pending.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)
      mar_q <= '0;
    else if (load_ok && mem.mar_in)
      mar_q <= mem.bus_in[8:0];
  end

  // MDR: RAM capture closes RD_CAP, bus load only when idle.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)
      mdr_q <= '0;
    else if (state_q == RD_CAP)
      mdr_q <= mem.ram_data_out;
    else if (load_ok && mem.mdr_in)
      mdr_q <= mem.bus_in;
  end

`ifdef MAR_RANGE_CHECK_EN
  // Range flag follows every accepted MAR load.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)
      err_q <= 1'b0;
    else if (load_ok && mem.mar_in)
      err_q <= |mem.bus_in[31:9];
  end
`else
  logic unused_hi_bits;
  assign unused_hi_bits = ^mem.bus_in[31:9];
  assign err_q = 1'b0;
`endif

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: sync RAM, access-plan model, directed tests.
// Per-cycle compare on the falling edge plus literal checks.
module tb_mem_interface;

  logic clock = 1'b0;
  logic clear_n = 1'b0;

  mem_interface_if bus_if ();

  mem_interface dut (
    .clock   (clock),
    .clear_n (clear_n),
    .mem     (bus_if.slave)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_done = 0;

  logic [31:0] ram [512];
  logic [31:0] mmem [512];

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]  = 32'hA500_0000 | i;
      mmem[i] = 32'hA500_0000 | i;
    end
    ram[9'h095]  = 32'h0000_0022;
    mmem[9'h095] = 32'h0000_0022;
  end

  // Sync RAM: read data valid one cycle after the strobe edge.
  always @(posedge clock) begin
    if (!clear_n)
      bus_if.ram_data_out <= '0;
    else begin
      if (bus_if.ram_write)
        ram[bus_if.ram_address] <= bus_if.ram_data_in;
      if (bus_if.ram_read)
        bus_if.ram_data_out <= ram[bus_if.ram_address];
    end
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: an accepted request expands into a plan of cycles.
  typedef struct packed {
    logic rd;
    logic wr;
    logic cap;
    logic done;
  } cyc_t;

  cyc_t        plan [$];
  cyc_t        cur = '0;
  logic [8:0]  m_mar = '0;
  logic [31:0] m_mdr = '0;
  logic        m_err = 1'b0;

  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m_mar = '0;
      m_mdr = '0;
      m_err = 1'b0;
      cur   = '0;
      plan.delete();
    end else begin
      automatic logic was_idle = (cur == '0);
      if (cur.wr)  mmem[m_mar] = m_mdr;
      if (cur.cap) m_mdr = mmem[m_mar];
      cur = '0;
      if (plan.size() > 0)
        cur = plan.pop_front();
      else if (was_idle) begin
        if (bus_if.mem_write_req || bus_if.mem_read_req) begin
          if (m_err)
            plan.push_back(4'b0001);
          else if (bus_if.mem_write_req) begin
            plan.push_back(4'b0100);
            plan.push_back(4'b0001);
          end else begin
            plan.push_back(4'b1000);
            plan.push_back(4'b0010);
            plan.push_back(4'b0001);
          end
          cur = plan.pop_front();
        end else begin
          if (bus_if.mar_in) begin
            m_mar = bus_if.bus_in[8:0];
`ifdef MAR_RANGE_CHECK_EN
            m_err = |bus_if.bus_in[31:9];
`endif
          end
          if (bus_if.mdr_in) m_mdr = bus_if.bus_in;
        end
      end
    end
  end

  // Per-cycle compare and strobe counters.
  always @(negedge clock) begin
    chk("busy", bus_if.busy, cur != '0);
    chk("ram_read", bus_if.ram_read, cur.rd);
    chk("ram_write", bus_if.ram_write, cur.wr);
    chk("mem_done", bus_if.mem_done, cur.done);
    chk("ram_address", bus_if.ram_address, m_mar);
    chk("ram_data_in", bus_if.ram_data_in, m_mdr);
    chk("mdr_out", bus_if.mdr_out_data, m_mdr);
    chk("addr_err", bus_if.addr_err, m_err);
    if (bus_if.ram_read)  n_rd++;
    if (bus_if.ram_write) n_wr++;
    if (bus_if.mem_done)  n_done++;
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic quiet();
    bus_if.bus_in        = '0;
    bus_if.mar_in        = 1'b0;
    bus_if.mdr_in        = 1'b0;
    bus_if.mem_read_req  = 1'b0;
    bus_if.mem_write_req = 1'b0;
  endtask

  task automatic load_mar(logic [31:0] v);
    bus_if.bus_in = v;
    bus_if.mar_in = 1'b1;
    step();
    bus_if.mar_in = 1'b0;
  endtask

  task automatic load_mdr(logic [31:0] v);
    bus_if.bus_in = v;
    bus_if.mdr_in = 1'b1;
    step();
    bus_if.mdr_in = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus_if.mem_done && k < 10) begin
      step();
      k++;
    end
    chk("done_seen", bus_if.mem_done, 1'b1);
    step();
  endtask

  task automatic do_read();
    bus_if.mem_read_req = 1'b1;
    step();
    bus_if.mem_read_req = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, d0;
    quiet();
    #1;
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_done", bus_if.mem_done, 1'b0);
    chk("rst_rd", bus_if.ram_read, 1'b0);
    chk("rst_wr", bus_if.ram_write, 1'b0);
    chk("rst_mdr", bus_if.mdr_out_data, 32'h0);
    chk("rst_addr", bus_if.ram_address, 9'h0);
    chk("rst_err", bus_if.addr_err, 1'b0);
    step();
    step();
    clear_n = 1'b1;
    step();

    // Read of RAM[0x95] with cycle-exact latency.
    load_mar(32'h95);
    bus_if.mem_read_req = 1'b1;
    step();
    bus_if.mem_read_req = 1'b0;
    chk("t1_rd_c1", bus_if.ram_read, 1'b1);
    step();
    chk("t1_rd_c2", bus_if.ram_read, 1'b0);
    chk("t1_busy_c2", bus_if.busy, 1'b1);
    step();
    chk("t1_mdr", bus_if.mdr_out_data, 32'h22);
    chk("t1_done_c3", bus_if.mem_done, 1'b1);
    step();
    chk("t1_idle", bus_if.busy, 1'b0);
    chk("t1_done_c4", bus_if.mem_done, 1'b0);

    // Write 0xDEADBEEF to 0x87 and read it back.
    load_mar(32'h87);
    load_mdr(32'hDEADBEEF);
    w0 = n_wr;
    bus_if.mem_write_req = 1'b1;
    step();
    bus_if.mem_write_req = 1'b0;
    chk("t2_wr", bus_if.ram_write, 1'b1);
    chk("t2_addr", bus_if.ram_address, 9'h087);
    wait_done();
    chk("t2_nwr", n_wr - w0, 1);
    load_mdr(32'h0);
    do_read();
    chk("t2_rb", bus_if.mdr_out_data, 32'hDEADBEEF);

    // Read and write together: write wins.
    load_mar(32'h40);
    load_mdr(32'h5);
    r0 = n_rd;
    w0 = n_wr;
    bus_if.mem_read_req  = 1'b1;
    bus_if.mem_write_req = 1'b1;
    step();
    quiet();
    wait_done();
    chk("t3_nrd", n_rd - r0, 0);
    chk("t3_nwr", n_wr - w0, 1);
    load_mdr(32'h0);
    do_read();
    chk("t3_rb", bus_if.mdr_out_data, 32'h5);

    // Load and request while busy are ignored.
    load_mar(32'h95);
    d0 = n_done;
    w0 = n_wr;
    bus_if.mem_read_req = 1'b1;
    step();
    bus_if.mem_read_req  = 1'b0;
    bus_if.bus_in        = 32'h1;
    bus_if.mdr_in        = 1'b1;
    bus_if.mem_write_req = 1'b1;
    step();
    quiet();
    wait_done();
    step();
    step();
    chk("t4_ndone", n_done - d0, 1);
    chk("t4_nwr", n_wr - w0, 0);
    chk("t4_mdr", bus_if.mdr_out_data, 32'h22);

    // Same-edge MAR load uses the old MAR for the access.
    load_mar(32'h87);
    bus_if.bus_in       = 32'h10;
    bus_if.mar_in       = 1'b1;
    bus_if.mem_read_req = 1'b1;
    step();
    quiet();
    wait_done();
    chk("t5_mdr", bus_if.mdr_out_data, 32'hDEADBEEF);

    // Back-to-back: held read accepted every 4 edges.
    d0 = n_done;
    bus_if.mem_read_req = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus_if.mem_read_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t6_ndone", n_done - d0, 3);

    // Reset during WR aborts the write.
    load_mar(32'h30);
    load_mdr(32'h1234);
    w0 = n_wr;
    d0 = n_done;
    bus_if.mem_write_req = 1'b1;
    step();
    bus_if.mem_write_req = 1'b0;
    #1 clear_n = 1'b0;
    #1;
    chk("t7_wr", bus_if.ram_write, 1'b0);
    chk("t7_busy", bus_if.busy, 1'b0);
    chk("t7_mdr", bus_if.mdr_out_data, 32'h0);
    step();
    step();
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t7_nwr", n_wr - w0, 0);
    chk("t7_ndone", n_done - d0, 0);
    chk("t7_ram", ram[9'h030], 32'hA500_0030);

    // Out-of-range MAR load.
    load_mar(32'h200);
    chk("t8_addr", bus_if.ram_address, 9'h0);
    r0 = n_rd;
    d0 = n_done;
    do_read();
    chk("t8_ndone", n_done - d0, 1);
`ifdef MAR_RANGE_CHECK_EN
    chk("t8_err", bus_if.addr_err, 1'b1);
    chk("t8_nrd", n_rd - r0, 0);
    chk("t8_mdr", bus_if.mdr_out_data, 32'h0);
`else
    chk("t8_err", bus_if.addr_err, 1'b0);
    chk("t8_nrd", n_rd - r0, 1);
    chk("t8_mdr", bus_if.mdr_out_data, 32'hA500_0000);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
